// File: rtl/seg_page_sched.sv
// Display-page scheduler: debounces panel keys, shadows measurement results and
// swaps the 7-segment display word only on driver frame boundaries.
module seg_page_sched #(
  parameter int DEB_CYC    = 250000,
  parameter int ROT_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_sel,
  input  logic        key_mode,
  input  logic [31:0] val0,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] val3,
  input  logic        val_vld,
  input  logic        frame_done,
  output logic [31:0] disp_word,
  output logic [7:0]  disp_blank,
  output logic [1:0]  page,
  output logic        auto_mode
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_t;

  logic [1:0] key_raw;
  logic [1:0] press_p;
  logic       sel_p;
  logic       mode_p;

  assign key_raw = {key_mode, key_sel};
  assign sel_p   = press_p[0];
  assign mode_p  = press_p[1];

  // Per key: 2-flop synchronizer, stability counter, registered press pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic          press_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          deb_reg   <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEB_CYC - 1)) begin
            deb_reg   <= sync2_reg;
            cnt_reg   <= '0;
            press_reg <= ~sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press_p[gi] = press_reg;
    end
  endgenerate

  mode_t       state_reg, state_next;
  logic [1:0]  pg_reg, pg_next;
  logic [15:0] fc_reg, fc_next;

  // Event priority: mode toggle, then manual skip, then timed rotation.
  always_comb begin
    state_next = state_reg;
    pg_next    = pg_reg;
    fc_next    = fc_reg;
    if (mode_p) begin
      state_next = (state_reg == MANUAL) ? AUTO : MANUAL;
      fc_next    = '0;
    end
    if (sel_p) begin
      pg_next = pg_reg + 2'd1;
      fc_next = '0;
    end else if (state_next == AUTO && frame_done) begin
      if (fc_next == 16'(ROT_FRAMES - 1)) begin
        pg_next = pg_reg + 2'd1;
        fc_next = '0;
      end else begin
        fc_next = fc_next + 16'd1;
      end
    end
  end

  logic [31:0] shadow_reg [4];
  logic [31:0] val_arr    [4];
  logic [31:0] word_next;
  logic [7:0]  blank_next;
  logic [31:0] word_reg;
  logic [7:0]  blank_reg;
  logic [1:0]  page_reg;

  assign val_arr[0] = val0;
  assign val_arr[1] = val1;
  assign val_arr[2] = val2;
  assign val_arr[3] = val3;

  // A result arriving on the frame boundary itself bypasses the shadow.
  assign word_next = val_vld ? val_arr[pg_next] : shadow_reg[pg_next];

  assign blank_next[0] = 1'b0;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_blank
      assign blank_next[gi] = (word_next[31:4*gi] == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MANUAL;
      pg_reg    <= '0;
      fc_reg    <= '0;
      word_reg  <= '0;
      blank_reg <= 8'hFE;
      page_reg  <= '0;
      for (int k = 0; k < 4; k++) shadow_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      pg_reg    <= pg_next;
      fc_reg    <= fc_next;
      if (val_vld) begin
        for (int k = 0; k < 4; k++) shadow_reg[k] <= val_arr[k];
      end
      if (frame_done) begin
        word_reg  <= word_next;
        blank_reg <= blank_next;
        page_reg  <= pg_next;
      end
    end
  end

  assign disp_word  = word_reg;
  assign disp_blank = blank_reg;
  assign page       = page_reg;
  assign auto_mode  = (state_reg == AUTO);

endmodule

// File: tb/tb_seg_page_sched.sv
// Bench for seg_page_sched: directed scenarios plus randomized operations,
// checked against an event-level model of pages, rotation and shadows.
module tb_seg_page_sched;

  localparam int DEB = 4;
  localparam int ROT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_sel = 1'b1;
  logic        key_mode = 1'b1;
  logic [31:0] val0 = '0, val1 = '0, val2 = '0, val3 = '0;
  logic        val_vld = 1'b0;
  logic        frame_done = 1'b0;
  logic [31:0] disp_word;
  logic [7:0]  disp_blank;
  logic [1:0]  page;
  logic        auto_mode;

  seg_page_sched #(.DEB_CYC(DEB), .ROT_FRAMES(ROT)) dut (
    .clk(clk), .rst(rst), .key_sel(key_sel), .key_mode(key_mode),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .val_vld(val_vld), .frame_done(frame_done),
    .disp_word(disp_word), .disp_blank(disp_blank),
    .page(page), .auto_mode(auto_mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event-level reference model
  logic [1:0]  m_pg, m_page;
  logic        m_auto;
  int          m_fc;
  logic [31:0] m_sh [4];
  logic [31:0] m_word;
  logic [7:0]  m_blank;

  // Leading-zero digits are blanked; at least one digit always shows.
  function automatic logic [7:0] blank_of(input logic [31:0] w);
    int n = 1;
    logic [15:0] t;
    for (int i = 0; i < 8; i++) if (((w >> (4 * i)) & 32'hF) != 0) n = i + 1;
    t = 16'h00FF << n;
    return t[7:0];
  endfunction

  function automatic logic [31:0] rv();
    return $urandom >> $urandom_range(0, 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pg = 0; m_page = 0; m_auto = 0; m_fc = 0;
    for (int k = 0; k < 4; k++) m_sh[k] = '0;
    m_word = '0; m_blank = 8'hFE;
  endtask

  task automatic key_pulse(input bit is_mode, input int lo);
    if (is_mode) key_mode = 1'b0; else key_sel = 1'b0;
    repeat (lo) tick();
    key_mode = 1'b1; key_sel = 1'b1;
    repeat (10) tick();
  endtask

  task automatic press(input bit is_mode);
    key_pulse(is_mode, 10);
    if (is_mode) m_auto = ~m_auto;
    else m_pg = m_pg + 2'd1;
    m_fc = 0;
  endtask

  task automatic frame(input bit vld, input logic [31:0] a, b, c, d);
    val0 = a; val1 = b; val2 = c; val3 = d;
    val_vld = vld; frame_done = 1'b1;
    tick();
    val_vld = 1'b0; frame_done = 1'b0;
    if (vld) begin m_sh[0] = a; m_sh[1] = b; m_sh[2] = c; m_sh[3] = d; end
    if (m_auto) begin
      m_fc++;
      if (m_fc == ROT) begin m_pg = m_pg + 2'd1; m_fc = 0; end
    end
    m_page = m_pg; m_word = m_sh[m_pg]; m_blank = blank_of(m_word);
  endtask

  task automatic load(input logic [31:0] a, b, c, d);
    val0 = a; val1 = b; val2 = c; val3 = d; val_vld = 1'b1;
    tick();
    val_vld = 1'b0;
    m_sh[0] = a; m_sh[1] = b; m_sh[2] = c; m_sh[3] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp += 4;
    if (disp_word !== 32'h0) begin n_bad++; $display("FAIL reset_word got %h want 00000000", disp_word); end
    if (disp_blank !== 8'hFE) begin n_bad++; $display("FAIL reset_blank got %h want fe", disp_blank); end
    if (page !== 2'd0) begin n_bad++; $display("FAIL reset_page got %0d want 0", page); end
    if (auto_mode !== 1'b0) begin n_bad++; $display("FAIL reset_auto got %b want 0", auto_mode); end
    rst = 1'b0;
    model_reset();
    $display("reset: word=%h blank=%h page=%0d auto=%b", disp_word, disp_blank, page, auto_mode);
  endtask

  task automatic test_first_frame();
    frame(1'b1, 32'h0001_2345, rv(), rv(), rv());
    n_cmp += 4;
    if (disp_word !== 32'h0001_2345) begin n_bad++; $display("FAIL first_word got %h want 00012345", disp_word); end
    if (disp_blank !== 8'hE0) begin n_bad++; $display("FAIL first_blank got %h want e0", disp_blank); end
    if (page !== 2'd0) begin n_bad++; $display("FAIL first_page got %0d want 0", page); end
    if (auto_mode !== 1'b0) begin n_bad++; $display("FAIL first_auto got %b want 0", auto_mode); end
    $display("first_frame: word=%h blank=%h", disp_word, disp_blank);
  endtask

  task automatic test_debounce();
    key_pulse(1'b0, 3);
    frame(1'b0, val0, val1, val2, val3);
    n_cmp++;
    if (page !== 2'd0) begin n_bad++; $display("FAIL bounce_page got %0d want 0", page); end
    press(1'b0);
    n_cmp++;
    if (page !== 2'd0) begin n_bad++; $display("FAIL press_before_frame got %0d want 0", page); end
    frame(1'b0, val0, val1, val2, val3);
    n_cmp += 2;
    if (page !== 2'd1) begin n_bad++; $display("FAIL press_after_frame got %0d want 1", page); end
    if (disp_word !== m_word) begin n_bad++; $display("FAIL press_word got %h want %h", disp_word, m_word); end
    key_pulse(1'b0, 100);
    m_pg = m_pg + 2'd1;
    frame(1'b0, val0, val1, val2, val3);
    n_cmp++;
    if (page !== 2'd2) begin n_bad++; $display("FAIL held_page got %0d want 2", page); end
    $display("debounce: page=%0d", page);
  endtask

  task automatic test_cycle();
    load(32'h0, rv(), rv(), rv());
    while (m_pg != 2'd0) press(1'b0);
    frame(1'b0, val0, val1, val2, val3);
    n_cmp += 2;
    if (disp_word !== 32'h0) begin n_bad++; $display("FAIL zero_word got %h want 00000000", disp_word); end
    if (disp_blank !== 8'hFE) begin n_bad++; $display("FAIL zero_blank got %h want fe", disp_blank); end
    for (int k = 1; k <= 4; k++) begin
      press(1'b0);
      frame(1'b0, val0, val1, val2, val3);
      n_cmp += 3;
      if (page !== 2'(k % 4)) begin n_bad++; $display("FAIL cycle_page got %0d want %0d", page, k % 4); end
      if (disp_word !== m_sh[k % 4]) begin n_bad++; $display("FAIL cycle_word got %h want %h", disp_word, m_sh[k % 4]); end
      if (disp_blank !== blank_of(m_sh[k % 4])) begin n_bad++; $display("FAIL cycle_blank got %h want %h", disp_blank, blank_of(m_sh[k % 4])); end
      $display("cycle: page=%0d word=%h blank=%h", page, disp_word, disp_blank);
    end
  endtask

  task automatic test_auto();
    logic [1:0] exp_a [6];
    logic [1:0] exp_b [3];
    exp_a = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    exp_b = '{2'd3, 2'd3, 2'd0};
    press(1'b1);
    n_cmp++;
    if (auto_mode !== 1'b1) begin n_bad++; $display("FAIL auto_on got %b want 1", auto_mode); end
    for (int i = 0; i < 6; i++) begin
      frame(1'b0, val0, val1, val2, val3);
      n_cmp += 2;
      if (page !== exp_a[i]) begin n_bad++; $display("FAIL auto_page frame %0d got %0d want %0d", i + 1, page, exp_a[i]); end
      if (disp_word !== m_word) begin n_bad++; $display("FAIL auto_word got %h want %h", disp_word, m_word); end
      $display("auto: frame=%0d page=%0d", i + 1, page);
    end
    press(1'b0);
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, val0, val1, val2, val3);
      n_cmp++;
      if (page !== exp_b[i]) begin n_bad++; $display("FAIL skip_page frame %0d got %0d want %0d", i + 7, page, exp_b[i]); end
      $display("auto_skip: frame=%0d page=%0d", i + 7, page);
    end
  endtask

  task automatic test_bypass();
    while (m_pg != 2'd2) press(1'b0);
    frame(1'b1, rv(), rv(), 32'hDEAD_BEEF, rv());
    n_cmp += 3;
    if (page !== 2'd2) begin n_bad++; $display("FAIL bypass_page got %0d want 2", page); end
    if (disp_word !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass_word got %h want deadbeef", disp_word); end
    if (disp_blank !== 8'h00) begin n_bad++; $display("FAIL bypass_blank got %h want 00", disp_blank); end
    $display("bypass: page=%0d word=%h", page, disp_word);
  endtask

  task automatic test_reset_mid();
    while (m_fc != 2) frame(1'b0, val0, val1, val2, val3);
    key_sel = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp += 4;
    if (disp_word !== 32'h0) begin n_bad++; $display("FAIL mid_reset_word got %h want 00000000", disp_word); end
    if (disp_blank !== 8'hFE) begin n_bad++; $display("FAIL mid_reset_blank got %h want fe", disp_blank); end
    if (page !== 2'd0) begin n_bad++; $display("FAIL mid_reset_page got %0d want 0", page); end
    if (auto_mode !== 1'b0) begin n_bad++; $display("FAIL mid_reset_auto got %b want 0", auto_mode); end
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    key_sel = 1'b1;
    repeat (10) tick();
    frame(1'b0, val0, val1, val2, val3);
    n_cmp += 3;
    if (page !== 2'd0) begin n_bad++; $display("FAIL short_after_reset got %0d want 0", page); end
    if (auto_mode !== 1'b0) begin n_bad++; $display("FAIL auto_after_reset got %b want 0", auto_mode); end
    if (disp_word !== 32'h0) begin n_bad++; $display("FAIL shadow_after_reset got %h want 00000000", disp_word); end
    press(1'b0);
    frame(1'b0, val0, val1, val2, val3);
    n_cmp++;
    if (page !== 2'd1) begin n_bad++; $display("FAIL press_after_reset got %0d want 1", page); end
    $display("reset_mid: page=%0d auto=%b", page, auto_mode);
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 2) press(1'b0);
      else if (op == 2) press(1'b1);
      else if (op < 6) frame(1'b0, rv(), rv(), rv(), rv());
      else if (op < 8) frame(1'b1, rv(), rv(), rv(), rv());
      else load(rv(), rv(), rv(), rv());
      n_cmp += 4;
      if (page !== m_page) begin n_bad++; $display("FAIL rand_page it %0d got %0d want %0d", it, page, m_page); end
      if (disp_word !== m_word) begin n_bad++; $display("FAIL rand_word it %0d got %h want %h", it, disp_word, m_word); end
      if (disp_blank !== m_blank) begin n_bad++; $display("FAIL rand_blank it %0d got %h want %h", it, disp_blank, m_blank); end
      if (auto_mode !== m_auto) begin n_bad++; $display("FAIL rand_auto it %0d got %b want %b", it, auto_mode, m_auto); end
      $display("random: it=%0d op=%0d page=%0d word=%h blank=%h auto=%b", it, op, page, disp_word, disp_blank, auto_mode);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_frame();
    test_debounce();
    test_cycle();
    test_auto();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_page_sched.md
Name: seg_page_sched

Overview:
- Display-page scheduler between the measurement block (freq/duty/t1/t0 results) and the serial 7-segment display driver.
- Debounces the two front-panel keys and holds shadow copies of the four 32-bit results.
- Selects one page, manually or by timed auto-rotation.
- Updates the display word only at driver frame boundaries, so digits never tear mid-scan.

Parameters:
- DEB_CYC, 250000: clk cycles a synchronized key level must stay stable before it is accepted.
- ROT_FRAMES, 64: completed display frames per page in auto mode (≥2).

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- key_sel  in  1  raw page-select key, active-low, asynchronous to clk.
- key_mode  in  1  raw manual/auto toggle key, active-low, asynchronous to clk.
- val0  in  32  page 0 value (frequency count).
- val1  in  32  page 1 value (duty count).
- val2  in  32  page 2 value (t1).
- val3  in  32  page 3 value (t0).
- val_vld  in  1  one-cycle pulse: val0..val3 hold a new consistent result set.
- frame_done  in  1  one-cycle pulse from the display driver at the end of a full 8-digit scan.
- disp_word  out  32  8 hex nibbles to display; nibble 0 is the rightmost digit.
- disp_blank  out  8  per-digit blank mask, bit i blanks digit i.
- page  out  2  page currently shown.
- auto_mode  out  1  1 = auto-rotation active.

Behaviour:
- Reset (rst=1 at a posedge): disp_word=0, disp_blank=8'hFE, page=0, auto_mode=0.
  - Shadows, frame counter and debounce counters are cleared.
  - Debounced key states are set to 1 (released).
  - Synchronizer flops are set to 1.
  - Reset asserted mid-operation aborts everything, including partially counted debounces and frame counts.
- Key input path:
  - Each key passes through a 2-flop synchronizer.
  - A per-key counter increments while the synced level ≠ debounced state; it clears to 0 on any cycle where they are equal.
  - When the counter reaches DEB_CYC-1 and the levels still differ, the debounced state flips and the counter clears.
  - A 1→0 debounced flip produces a one-cycle press pulse (sel_p / mode_p). Release produces no event; a held key produces exactly one event.
- Shadows: on val_vld, shadow[k] <= val k for all four, all in the same cycle.
- Internal page register pg_nx, updated each cycle. Events apply in this order: mode_p, then sel_p, then rotation.
- Mode FSM, states MANUAL (auto_mode=0) and AUTO (auto_mode=1):
  - mode_p toggles the state and clears frame_cnt.
  - MANUAL: sel_p → pg_nx = pg_nx+1 mod 4. frame_done is ignored for rotation.
  - AUTO, frame counting: on frame_done, if frame_cnt == ROT_FRAMES-1 then pg_nx+1 mod 4 and frame_cnt=0; else frame_cnt+1.
  - AUTO, manual skip: sel_p → pg_nx+1 mod 4 and frame_cnt=0, and frame_done is not counted in that cycle.
  - mode_p and sel_p in the same cycle: the toggle and a single +1 both apply, and frame_cnt=0.
- Output update, only on a frame_done cycle (takes effect the next cycle):
  - page <= pg_nx value after this cycle's events.
  - disp_word <= selected shadow. If val_vld is also high that cycle, the new val input for that page is used (bypass).
  - disp_blank <= mask computed from the new word.
- Between frame_done pulses, disp_word, disp_blank and page are held stable.
- Blank mask: bit i=1 iff nibbles 7..i of the word are all zero, for i=1..7. Bit 0 is always 0 (a single "0" is shown for value 0). The mask is registered together with disp_word.
- frame_cnt: 16 bits, saturates never (it always wraps via the compare). ROT_FRAMES must fit in 16 bits.
- All page arithmetic is 2-bit wrap, so 3→0.

Test Plan:
- Reset, then DEB_CYC=4, val_vld with val0=32'h0001_2345, one frame_done → disp_word=32'h00012345, disp_blank=8'hE0, page=0, auto_mode=0.
- key_sel low for 3 cycles then high (bounce) → no page change. Low for ≥6 cycles → pg_nx=1, and page becomes 1 only after the next frame_done. Held low for 100 cycles → a single advance only.
- Four valid key_sel presses, each followed by frame_done → page sequence 1,2,3,0. disp_word tracks val1..val3 then val0. val=0 → disp_blank=8'hFE.
- key_mode press, ROT_FRAMES=3, 7 frame_done pulses → page stays 0 for frames 1–2, becomes 1 at frame 3 and 2 at frame 6. key_sel press during frame 7 → immediate +1, next rotation 3 frames later.
- frame_done and val_vld in the same cycle with val2=32'hDEAD_BEEF while page 2 is selected → disp_word=32'hDEADBEEF on the next cycle, not the stale shadow.
- rst pulse while in AUTO with frame_cnt=2 and key_sel mid-debounce → all outputs at reset values, auto_mode=0, and a release→press after reset needs the full DEB_CYC to register.
